// File: rtl/branch_ctrl_if.sv
// Branch controller bus: decode-side branch handshake, ALU flag
// write port, and the redirect/flush/stall/count outputs.
// master = decode/ALU side, slave = branch_ctrl.
interface branch_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_type;
    logic [15:0] br_offset;
    logic [15:0] br_pc;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        flush;
    logic        stall;
    logic [15:0] taken_cnt;

    modport master (
        output br_valid, br_type, br_offset, br_pc, flags_we, flags_in,
        input  br_ready, redirect_valid, redirect_addr, flush, stall, taken_cnt
    );

    modport slave (
        input  br_valid, br_type, br_offset, br_pc, flags_we, flags_in,
        output br_ready, redirect_valid, redirect_addr, flush, stall, taken_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branch/jump instructions against the stored ALU
// flags, issues a one-cycle PC redirect and holds flush for FLUSH_CYCLES.
// Optional macro BRANCH_FWD_EN: resolve in the accept cycle (zero latency).
`ifndef OP_JMP
`define OP_JMP  4'h1
`endif
`ifndef OP_BRZ
`define OP_BRZ  4'h2
`endif
`ifndef OP_BRNZ
`define OP_BRNZ 4'h3
`endif
`ifndef OP_BRNS
`define OP_BRNS 4'h4
`endif

module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_t;

    localparam logic [3:0] FC_LAST = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_flags;
    logic [3:0]  r_fcnt;
    logic        r_flush;
    logic        r_stall;
    logic [15:0] r_taken_cnt;

    logic [3:0]  w_flags_eff;
    logic        w_accept;
    logic        w_taken;
    logic [15:0] w_target;

    function automatic logic taken_fn(input logic [3:0] t, input logic z, input logic s);
        case (t)
            `OP_JMP:  taken_fn = 1'b1;
            `OP_BRZ:  taken_fn = z;
            `OP_BRNZ: taken_fn = ~z;
            `OP_BRNS: taken_fn = ~s;
            default:  taken_fn = 1'b0;
        endcase
    endfunction

    // A flag write on the accept edge is visible to the branch being resolved.
    assign w_flags_eff = bus.flags_we ? bus.flags_in : r_flags;
    assign w_accept    = bus.br_valid & bus.br_ready;
    assign w_taken     = taken_fn(bus.br_type, w_flags_eff[0], w_flags_eff[1]);
    assign w_target    = bus.br_pc + bus.br_offset;

    assign bus.br_ready  = (r_state == IDLE) && rst_n;
    assign bus.flush     = r_flush;
    assign bus.stall     = r_stall;
    assign bus.taken_cnt = r_taken_cnt;

`ifdef BRANCH_FWD_EN
    assign bus.redirect_valid = w_accept & w_taken;
    assign bus.redirect_addr  = (w_accept & w_taken) ? w_target : '0;
`else
    logic        r_redirect_valid;
    logic [15:0] r_redirect_addr;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_addr  = r_redirect_addr;
`endif

    // Flag register: loads on every write strobe regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_flags <= '0;
        else if (bus.flags_we) r_flags <= bus.flags_in;
    end

    // Branch FSM. The outcome is decided on the accept edge (with the flag
    // forward) so redirect_valid/addr are registered yet high in RESOLVE;
    // this equals resolving from stored_flags during RESOLVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_fcnt      <= '0;
            r_flush     <= 1'b0;
            r_stall     <= 1'b0;
            r_taken_cnt <= '0;
`ifndef BRANCH_FWD_EN
            r_redirect_valid <= 1'b0;
            r_redirect_addr  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
`ifdef BRANCH_FWD_EN
                        if (w_taken) begin
                            r_state <= FLUSH;
                            r_flush <= 1'b1;
                            r_stall <= 1'b1;
                            r_fcnt  <= FC_LAST;
                            if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
                        end
`else
                        r_state          <= RESOLVE;
                        r_stall          <= 1'b1;
                        r_redirect_valid <= w_taken;
                        r_redirect_addr  <= w_taken ? w_target : '0;
`endif
                    end
                end
                RESOLVE: begin
`ifdef BRANCH_FWD_EN
                    r_state <= IDLE;
                    r_stall <= 1'b0;
`else
                    r_redirect_valid <= 1'b0;
                    r_redirect_addr  <= '0;
                    if (r_redirect_valid) begin
                        r_state <= FLUSH;
                        r_flush <= 1'b1;
                        r_fcnt  <= FC_LAST;
                        if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
                    end else begin
                        r_state <= IDLE;
                        r_stall <= 1'b0;
                    end
`endif
                end
                FLUSH: begin
                    if (r_fcnt == '0) begin
                        r_state <= IDLE;
                        r_flush <= 1'b0;
                        r_stall <= 1'b0;
                    end else begin
                        r_fcnt <= r_fcnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_flush <= 1'b0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed, table-driven bench for branch_ctrl (FLUSH_CYCLES = 2).
`ifndef OP_JMP
`define OP_JMP  4'h1
`endif
`ifndef OP_BRZ
`define OP_BRZ  4'h2
`endif
`ifndef OP_BRNZ
`define OP_BRNZ 4'h3
`endif
`ifndef OP_BRNS
`define OP_BRNS 4'h4
`endif

module tb_branch_ctrl;
    localparam int FC = 2;
`ifdef BRANCH_FWD_EN
    localparam int RES = 0;
`else
    localparam int RES = 1;
`endif

    typedef struct {
        logic [3:0]  typ;
        logic [15:0] pc;
        logic [15:0] off;
        logic        we;
        logic [3:0]  fin;
        logic        taken;
        logic [15:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   mdl_cnt = 0;
    vec_t vecs[10];

    branch_ctrl_if bus();

    branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        bus.br_type   = v.typ;
        bus.br_pc     = v.pc;
        bus.br_offset = v.off;
        bus.flags_we  = v.we;
        bus.flags_in  = v.fin;
        bus.br_valid  = 1'b1;
`ifdef BRANCH_FWD_EN
        #1;
        chk("fwd_redirect_valid", idx, 32'(bus.redirect_valid), 32'(v.taken));
        chk("fwd_redirect_addr", idx, 32'(bus.redirect_addr), 32'(v.addr));
`endif
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        bus.flags_we = 1'b0;
        if (v.taken) mdl_cnt++;
`ifndef BRANCH_FWD_EN
        chk("redirect_valid", idx, 32'(bus.redirect_valid), 32'(v.taken));
        chk("redirect_addr", idx, 32'(bus.redirect_addr), 32'(v.addr));
        chk("resolve_stall", idx, 32'(bus.stall), 32'd1);
        chk("resolve_ready", idx, 32'(bus.br_ready), 32'd0);
        @(posedge clk); #1;
`endif
        if (v.taken) begin
            for (int k = 0; k < FC; k++) begin
                chk("flush_high", idx, 32'(bus.flush), 32'd1);
                chk("redirect_done", idx, 32'(bus.redirect_valid), 32'd0);
                @(posedge clk); #1;
            end
        end
        chk("flush_low", idx, 32'(bus.flush), 32'd0);
        chk("ready_back", idx, 32'(bus.br_ready), 32'd1);
        chk("stall_low", idx, 32'(bus.stall), 32'd0);
        chk("taken_cnt", idx, 32'(bus.taken_cnt), 32'(mdl_cnt));
    endtask

    initial begin
        int n_redir;
        //          type      pc        off       we    fin   taken addr
        vecs[0] = '{`OP_JMP,  16'h0100, 16'h0010, 1'b0, 4'h0, 1'b1, 16'h0110};
        vecs[1] = '{`OP_BRZ,  16'h0200, 16'hFFFC, 1'b1, 4'h1, 1'b1, 16'h01FC};
        vecs[2] = '{`OP_BRNZ, 16'h0300, 16'h0040, 1'b0, 4'h0, 1'b0, 16'h0000};
        vecs[3] = '{`OP_JMP,  16'hFFF0, 16'h0020, 1'b0, 4'h0, 1'b1, 16'h0010};
        vecs[4] = '{`OP_BRNS, 16'h1000, 16'h0100, 1'b1, 4'h2, 1'b0, 16'h0000};
        vecs[5] = '{`OP_BRNS, 16'h1000, 16'h8000, 1'b1, 4'h0, 1'b1, 16'h9000};
        vecs[6] = '{`OP_BRNZ, 16'h2000, 16'h0002, 1'b0, 4'h0, 1'b1, 16'h2002};
        vecs[7] = '{4'hF,     16'h3000, 16'h0004, 1'b1, 4'h1, 1'b0, 16'h0000};
        vecs[8] = '{`OP_BRZ,  16'h4000, 16'h0000, 1'b1, 4'hC, 1'b0, 16'h0000};
        vecs[9] = '{4'h0,     16'h5000, 16'h0010, 1'b0, 4'h0, 1'b0, 16'h0000};

        bus.br_valid = 1'b0; bus.br_type = '0; bus.br_pc = '0; bus.br_offset = '0;
        bus.flags_we = 1'b0; bus.flags_in = '0;

        // Reset values while rst_n is low.
        #2;
        chk("rst_redirect_valid", 0, 32'(bus.redirect_valid), 32'd0);
        chk("rst_redirect_addr", 0, 32'(bus.redirect_addr), 32'd0);
        chk("rst_flush", 0, 32'(bus.flush), 32'd0);
        chk("rst_stall", 0, 32'(bus.stall), 32'd0);
        chk("rst_taken_cnt", 0, 32'(bus.taken_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_ready", 0, 32'(bus.br_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // br_valid held through a taken branch: no second accept until IDLE.
        @(negedge clk);
        bus.br_type = `OP_JMP; bus.br_pc = 16'h0600; bus.br_offset = 16'h0004;
        bus.br_valid = 1'b1;
        @(posedge clk); #1;
        mdl_cnt++;
        n_redir = 0;
        for (int i = 0; i < RES + FC; i++) begin
            chk("hold_ready_low", i, 32'(bus.br_ready), 32'd0);
            if (bus.redirect_valid) n_redir++;
            @(posedge clk); #1;
        end
        chk("hold_redirects", 0, 32'(n_redir), 32'(RES));
        chk("hold_ready_idle", 0, 32'(bus.br_ready), 32'd1);
        chk("hold_cnt", 0, 32'(bus.taken_cnt), 32'(mdl_cnt));
        // Second accept on this edge, then into FLUSH.
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        mdl_cnt++;
        for (int i = 0; i < RES; i++) begin
            @(posedge clk); #1;
        end
        chk("hold2_flush", 0, 32'(bus.flush), 32'd1);
        chk("hold2_cnt", 0, 32'(bus.taken_cnt), 32'(mdl_cnt));

        // Reset mid-FLUSH clears outputs immediately.
        rst_n = 1'b0; #1;
        mdl_cnt = 0;
        chk("midflush_flush", 0, 32'(bus.flush), 32'd0);
        chk("midflush_cnt", 0, 32'(bus.taken_cnt), 32'd0);
        chk("midflush_stall", 0, 32'(bus.stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("postflush_redirect", i, 32'(bus.redirect_valid), 32'd0);
            chk("postflush_flush", i, 32'(bus.flush), 32'd0);
            chk("postflush_ready", i, 32'(bus.br_ready), 32'd1);
        end

`ifndef BRANCH_FWD_EN
        // Reset mid-RESOLVE abandons the branch.
        @(negedge clk);
        bus.br_type = `OP_JMP; bus.br_pc = 16'h0700; bus.br_offset = 16'h0008;
        bus.br_valid = 1'b1;
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        chk("midres_redirect", 0, 32'(bus.redirect_valid), 32'd1);
        rst_n = 1'b0; #1;
        chk("midres_redirect_rst", 0, 32'(bus.redirect_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("postres_redirect", i, 32'(bus.redirect_valid), 32'd0);
            chk("postres_flush", i, 32'(bus.flush), 32'd0);
            chk("postres_cnt", i, 32'(bus.taken_cnt), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
